// File: rtl/lsu_serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_serializer_pkg
// Description : Shared constants and types for the load/store serializer.
//               The word and address widths match the data memory's own
//               constants. The package also defines the serializer state
//               encoding and the default lane-index width.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_serializer_pkg;

    localparam int c_N_LANES          = 4;
    localparam int c_DATA_WORD_LENGTH = 16;
    localparam int c_ADDR_WIDTH       = 16;
    localparam int c_LANE_IDX_W       = (c_N_LANES > 1) ? $clog2(c_N_LANES) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } lsu_state_t;

endpackage
`default_nettype wire

// File: rtl/lsu_lane_picker.sv
`default_nettype none
// ============================================================================
// Module      : lsu_lane_picker
// Description : Combinational lowest-set-bit priority encoder. It picks the
//               next lane to service from the remaining-lane mask.
// Ports       : i_mask  - remaining active lanes (bit i = lane i)
//               o_idx   - index of the lowest set bit (0 when mask is empty)
//               o_any   - at least one bit of i_mask is set
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_lane_picker
    import lsu_serializer_pkg::*;
#(
    parameter int N_LANES = c_N_LANES,
    parameter int IDX_W   = (N_LANES > 1) ? $clog2(N_LANES) : 1
) (
    input  logic [N_LANES-1:0] i_mask,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    // Scan from the top down so the lowest set bit is the last assignment.
    always_comb begin
        o_idx = '0;
        o_any = |i_mask;
        for (int i = N_LANES - 1; i >= 0; i--) begin
            if (i_mask[i]) begin
                o_idx = IDX_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/lsu_serializer.sv
`default_nettype none
// ============================================================================
// Module      : lsu_serializer
// Description : Takes one warp-wide load/store request and serializes it into
//               single-lane accesses on a single-port data memory. Lanes are
//               serviced in ascending order, and inactive lanes cost no
//               cycles. Load data is gathered per lane and returned as one
//               warp-wide response with a single-cycle resp_valid pulse.
// Ports       : clk, reset      - clock (posedge), async active-high reset
//               req_*           - warp request (valid/ready handshake)
//               resp_valid      - one-cycle completion pulse
//               resp_rdata      - gathered load data, packed per lane
//               mem_write/addr/wdata - drive memory MemWrite/Address/WriteData
//               mem_rdata       - memory ReadData (combinational in mem_addr)
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_serializer
    import lsu_serializer_pkg::*;
#(
    parameter int N_LANES          = c_N_LANES,
    parameter int DATA_WORD_LENGTH = c_DATA_WORD_LENGTH,
    parameter int ADDR_WIDTH       = c_ADDR_WIDTH
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic                             req_write,
    input  logic [N_LANES-1:0]               req_lane_mask,
    input  logic [N_LANES*ADDR_WIDTH-1:0]    req_addr,
    input  logic [N_LANES*DATA_WORD_LENGTH-1:0] req_wdata,
    output logic                             resp_valid,
    output logic [N_LANES*DATA_WORD_LENGTH-1:0] resp_rdata,
    output logic                             mem_write,
    output logic [ADDR_WIDTH-1:0]            mem_addr,
    output logic [DATA_WORD_LENGTH-1:0]      mem_wdata,
    input  logic [DATA_WORD_LENGTH-1:0]      mem_rdata
);

    localparam int c_IDX_W = (N_LANES > 1) ? $clog2(N_LANES) : 1;

    lsu_state_t                  r_state;
    lsu_state_t                  w_state_nxt;

    logic                        r_write;
    logic [N_LANES-1:0]          r_mask;            // lanes still to be serviced
    logic [ADDR_WIDTH-1:0]       r_addr  [N_LANES];
    logic [DATA_WORD_LENGTH-1:0] r_wdata [N_LANES];
    logic [DATA_WORD_LENGTH-1:0] r_rdata [N_LANES];

    logic [c_IDX_W-1:0]          w_idx;
    logic                        w_any;
    logic [N_LANES-1:0]          w_lane_onehot;
    logic [N_LANES-1:0]          w_mask_after;
    logic                        w_accept;
    logic                        w_access_step;

    // ------------------------------------------------------------------
    // Lane selection
    // ------------------------------------------------------------------
    lsu_lane_picker #(
        .N_LANES (N_LANES),
        .IDX_W   (c_IDX_W)
    ) u_lane_picker (
        .i_mask (r_mask),
        .o_idx  (w_idx),
        .o_any  (w_any)
    );

    always_comb begin
        w_lane_onehot        = '0;
        w_lane_onehot[w_idx] = 1'b1;
    end

    assign w_mask_after  = r_mask & ~w_lane_onehot;
    assign w_accept      = (r_state == IDLE) && req_valid;
    assign w_access_step = (r_state == ACCESS) && w_any;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and memory-side outputs. The outputs are decoded from the
    // state rather than registered. An async reset forces IDLE, so it also
    // drops mem_write in the same instant.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        mem_write   = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;

        case (r_state)
            IDLE: begin
                req_ready = ~reset;
                if (w_accept) begin
                    w_state_nxt = (req_lane_mask == '0) ? DONE : ACCESS;
                end
            end

            ACCESS: begin
                mem_addr = r_addr[w_idx];
                if (r_write) begin
                    mem_write = 1'b1;
                    mem_wdata = r_wdata[w_idx];
                end
                // An empty mask here should be unreachable. If it happens,
                // finish the request instead of stalling.
                if (!w_any || (w_mask_after == '0)) begin
                    w_state_nxt = DONE;
                end
            end

            DONE: begin
                resp_valid  = 1'b1;
                w_state_nxt = IDLE;
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request latch, remaining-mask update and load-data gather
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_write <= 1'b0;
            r_mask  <= '0;
            for (int i = 0; i < N_LANES; i++) begin
                r_addr[i]  <= '0;
                r_wdata[i] <= '0;
                r_rdata[i] <= '0;
            end
        end else if (w_accept) begin
            r_write <= req_write;
            r_mask  <= req_lane_mask;
            for (int i = 0; i < N_LANES; i++) begin
                r_addr[i]  <= req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                r_wdata[i] <= req_wdata[i*DATA_WORD_LENGTH +: DATA_WORD_LENGTH];
                r_rdata[i] <= '0;
            end
        end else if (w_access_step) begin
            r_mask <= w_mask_after;
            if (!r_write) begin
                r_rdata[w_idx] <= mem_rdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Pack gathered lanes onto the response bus
    // ------------------------------------------------------------------
    for (genvar g = 0; g < N_LANES; g++) begin : g_pack
        assign resp_rdata[g*DATA_WORD_LENGTH +: DATA_WORD_LENGTH] = r_rdata[g];
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_serializer
// Description : Self-checking bench for lsu_serializer. It contains a
//               behavioural single-port memory, directed vectors, a
//               mid-access reset sequence and randomized requests. These
//               are checked against a lane-ordered reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_serializer;

    localparam int NL = 4;
    localparam int DW = 16;
    localparam int AW = 16;

    logic               clk = 1'b0;
    logic               reset;
    logic               req_valid;
    logic               req_ready;
    logic               req_write;
    logic [NL-1:0]      req_lane_mask;
    logic [NL*AW-1:0]   req_addr;
    logic [NL*DW-1:0]   req_wdata;
    logic               resp_valid;
    logic [NL*DW-1:0]   resp_rdata;
    logic               mem_write;
    logic [AW-1:0]      mem_addr;
    logic [DW-1:0]      mem_wdata;
    logic [DW-1:0]      mem_rdata;

    always #5 clk = ~clk;

    lsu_serializer #(
        .N_LANES          (NL),
        .DATA_WORD_LENGTH (DW),
        .ADDR_WIDTH       (AW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_write     (req_write),
        .req_lane_mask (req_lane_mask),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .mem_write     (mem_write),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata)
    );

    // Single-port memory: synchronous write, combinational read.
    logic [DW-1:0] mem [0:65535];
    logic          mem_clr;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 65536; i++) mem[i] <= '0;
        end else if (mem_write) begin
            mem[mem_addr] <= mem_wdata;
        end
    end
    assign mem_rdata = mem[mem_addr];

    // Reference memory. Stores are applied in ascending lane order.
    logic [DW-1:0] model_mem [0:65535];

    int n_tests;
    int n_fail;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, then check every cycle up to the IDLE cycle after
    // DONE. The expected response comes from the reference memory.
    task automatic run_req(input bit wr, input logic [NL-1:0] m,
                           input logic [NL*AW-1:0] a, input logic [NL*DW-1:0] d,
                           output logic [NL*DW-1:0] got);
        int           lanes[$];
        logic [NL*DW-1:0] exp_rd;
        int           waited;
        logic [AW-1:0] ad;

        waited = 0;
        while (req_ready !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        chk("ready_before_accept", req_ready, 1);

        exp_rd = '0;
        for (int i = 0; i < NL; i++) if (m[i]) lanes.push_back(i);
        if (!wr) begin
            foreach (lanes[j]) begin
                ad = a[lanes[j]*AW +: AW];
                exp_rd[lanes[j]*DW +: DW] = model_mem[ad];
            end
        end

        req_valid     = 1'b1;
        req_write     = wr;
        req_lane_mask = m;
        req_addr      = a;
        req_wdata     = d;
        tick();   // accept edge T

        for (int n = 0; n < lanes.size(); n++) begin
            chk("access_resp_valid", resp_valid, 0);
            chk("access_req_ready", req_ready, 0);
            chk("access_mem_write", mem_write, wr);
            chk("access_mem_addr", mem_addr, a[lanes[n]*AW +: AW]);
            chk("access_mem_wdata", mem_wdata, wr ? d[lanes[n]*DW +: DW] : 16'h0);
            // The DUT must ignore request inputs outside IDLE.
            req_valid     = 1'b1;
            req_write     = 1'($urandom_range(0, 1));
            req_lane_mask = NL'($urandom);
            req_addr      = {$urandom(), $urandom()};
            req_wdata     = {$urandom(), $urandom()};
            tick();
        end
        req_valid = 1'b0;

        chk("done_resp_valid", resp_valid, 1);
        chk("done_req_ready", req_ready, 0);
        chk("done_mem_write", mem_write, 0);
        chk("done_mem_addr", mem_addr, 0);
        chk("done_mem_wdata", mem_wdata, 0);
        chk("done_resp_rdata", resp_rdata, exp_rd);
        got = resp_rdata;
        tick();

        chk("idle_resp_valid", resp_valid, 0);
        chk("idle_req_ready", req_ready, 1);
        chk("idle_mem_write", mem_write, 0);
        chk("idle_rdata_held", resp_rdata, exp_rd);

        if (wr) begin
            foreach (lanes[j]) model_mem[a[lanes[j]*AW +: AW]] = d[lanes[j]*DW +: DW];
            foreach (lanes[j]) begin
                ad = a[lanes[j]*AW +: AW];
                chk("memory_contents", mem[ad], model_mem[ad]);
            end
        end
    endtask

    typedef struct {
        bit               wr;
        logic [NL-1:0]    mask;
        logic [NL*AW-1:0] addr;
        logic [NL*DW-1:0] wdata;
        logic [NL*DW-1:0] exp_rd;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [NL*DW-1:0] got;
        logic [NL*AW-1:0] ra;
        logic [NL*DW-1:0] rd;
        int               resp_seen;

        n_tests       = 0;
        n_fail        = 0;
        reset         = 1'b1;
        mem_clr       = 1'b1;
        req_valid     = 1'b0;
        req_write     = 1'b0;
        req_lane_mask = '0;
        req_addr      = '0;
        req_wdata     = '0;
        for (int i = 0; i < 65536; i++) model_mem[i] = '0;

        vecs[0] = '{1'b1, 4'hF, {16'd3, 16'd2, 16'd1, 16'd0},
                    {16'hA003, 16'hA002, 16'hA001, 16'hA000}, 64'h0};
        vecs[1] = '{1'b0, 4'hF, {16'd3, 16'd2, 16'd1, 16'd0}, 64'h0,
                    {16'hA003, 16'hA002, 16'hA001, 16'hA000}};
        vecs[2] = '{1'b1, 4'b1010, {16'd9, 16'h0033, 16'd5, 16'h0044},
                    {16'h2222, 16'hBEEF, 16'h1111, 16'hDEAD}, 64'h0};
        vecs[3] = '{1'b0, 4'b1010, {16'd9, 16'd1, 16'd5, 16'd2}, 64'h0,
                    {16'h2222, 16'h0000, 16'h1111, 16'h0000}};
        vecs[4] = '{1'b0, 4'b0000, {16'd1, 16'd2, 16'd3, 16'd0}, 64'h0, 64'h0};
        vecs[5] = '{1'b1, 4'b0000, 64'h0, {4{16'hFFFF}}, 64'h0};
        vecs[6] = '{1'b1, 4'hF, {4{16'd7}},
                    {16'hD003, 16'hD002, 16'hD001, 16'hD000}, 64'h0};
        vecs[7] = '{1'b0, 4'b1001, {16'd7, 16'd1, 16'd2, 16'd7}, 64'h0,
                    {16'hD003, 16'h0000, 16'h0000, 16'hD003}};

        tick();
        tick();
        chk("reset_req_ready", req_ready, 0);
        chk("reset_resp_valid", resp_valid, 0);
        chk("reset_mem_write", mem_write, 0);
        chk("reset_mem_addr", mem_addr, 0);
        chk("reset_mem_wdata", mem_wdata, 0);
        chk("reset_resp_rdata", resp_rdata, 0);
        mem_clr = 1'b0;
        reset   = 1'b0;
        tick();
        chk("ready_after_reset", req_ready, 1);

        // Directed vectors
        for (int i = 0; i < 8; i++) begin
            run_req(vecs[i].wr, vecs[i].mask, vecs[i].addr, vecs[i].wdata, got);
            chk("table_rdata", got, vecs[i].exp_rd);
        end
        chk("mem0_after_store", mem[0], 16'hA000);
        chk("mem1_after_store", mem[1], 16'hA001);
        chk("mem3_after_store", mem[3], 16'hA003);
        chk("mem7_dup_addr_last_lane", mem[7], 16'hD003);

        // Reset during the second ACCESS cycle of a 4-lane store
        req_valid     = 1'b1;
        req_write     = 1'b1;
        req_lane_mask = 4'hF;
        req_addr      = {16'd13, 16'd12, 16'd11, 16'd10};
        req_wdata     = {16'hC003, 16'hC002, 16'hC001, 16'hC000};
        tick();
        chk("rst_seq_lane0_addr", mem_addr, 10);
        chk("rst_seq_lane0_write", mem_write, 1);
        tick();
        chk("rst_seq_lane1_addr", mem_addr, 11);
        reset     = 1'b1;
        req_valid = 1'b0;
        #1;
        chk("rst_seq_mem_write_drop", mem_write, 0);
        chk("rst_seq_mem_addr", mem_addr, 0);
        chk("rst_seq_req_ready", req_ready, 0);
        chk("rst_seq_resp_valid", resp_valid, 0);
        tick();
        reset = 1'b0;
        #1;
        chk("rst_seq_ready_after", req_ready, 1);
        chk("rst_seq_rdata_cleared", resp_rdata, 0);
        resp_seen = 0;
        for (int c = 0; c < 6; c++) begin
            if (resp_valid !== 1'b0) resp_seen++;
            tick();
        end
        chk("rst_seq_no_resp", resp_seen, 0);
        chk("rst_seq_mem10", mem[10], 16'hC000);
        chk("rst_seq_mem11", mem[11], 16'h0000);
        chk("rst_seq_mem12", mem[12], 16'h0000);
        chk("rst_seq_mem13", mem[13], 16'h0000);
        model_mem[10] = 16'hC000;

        // Randomized requests over a small address window to force reuse
        for (int r = 0; r < 40; r++) begin
            for (int l = 0; l < NL; l++) begin
                ra[l*AW +: AW] = AW'($urandom_range(0, 15));
                rd[l*DW +: DW] = DW'($urandom);
            end
            run_req(1'($urandom_range(0, 1)), NL'($urandom), ra, rd, got);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
